// File: rtl/arcade_ioctl_router.sv
// HPS ioctl front end: ROM/DIP/mod routing plus game-core reset sequencing; IOCTL_ROM_CHECKSUM_EN adds rom_sum.
// Latency: every output is registered, 1 clk after the sampled ioctl strobe or reset cause.
// No backpressure: ioctl strobes are always accepted; core_reset_n is the only throttle on the core.
module arcade_ioctl_router #(
    parameter int          AW          = 25,
    parameter int          NUM_DIP     = 8,
    parameter logic [7:0]  ROM_INDEX   = 8'd0,
    parameter logic [7:0]  MOD_INDEX   = 8'd1,
    parameter logic [7:0]  DIP_INDEX   = 8'd254,
    parameter int          HOLD_CYCLES = 16
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ext_reset,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [7:0]           ioctl_index,
    input  logic [AW-1:0]        ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic [8*NUM_DIP-1:0] dip,
    output logic [7:0]           mod_sel,
    output logic                 rom_wr,
    output logic [AW-1:0]        rom_addr,
    output logic [7:0]           rom_data,
    output logic [AW:0]          rom_len,
    output logic                 dl_done,
    output logic                 core_reset_n,
    output logic [15:0]          rom_sum
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {RUN = 2'd0, DOWNLOAD = 2'd1, HOLD = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [7:0]           idx_q, idx_d;
    logic                 dl_done_q, dl_done_d;
    logic                 core_rst_n_q;
    logic                 rom_wr_q;
    logic [AW-1:0]        rom_addr_q, rom_addr_d;
    logic [7:0]           rom_data_q, rom_data_d;
    logic [AW:0]          rom_len_q, rom_len_d, len_base;
    logic [8*NUM_DIP-1:0] dip_q, dip_d;
    logic [7:0]           mod_q, mod_d;
    logic                 rom_hit, rom_start, dip_hit;
    logic [AW:0]          addr_p1;

    assign rom_hit   = ioctl_wr & ioctl_download & (ioctl_index == ROM_INDEX);
    assign rom_start = (state_q != DOWNLOAD) & ioctl_download & (ioctl_index == ROM_INDEX);
    assign dip_hit   = ioctl_wr & (ioctl_index == DIP_INDEX);
    assign addr_p1   = {1'b0, ioctl_addr} + {{AW{1'b0}}, 1'b1};

    // Reset sequencing: download beats ext_reset beats the hold countdown.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        dl_done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (ioctl_download) begin
                    state_d = DOWNLOAD;
                    idx_d   = ioctl_index;
                end else if (ext_reset) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            DOWNLOAD: begin
                if (!ioctl_download) begin
                    state_d   = HOLD;
                    cnt_d     = '0;
                    dl_done_d = (idx_q == ROM_INDEX);
                end
            end
            HOLD: begin
                if (ioctl_download) begin
                    state_d = DOWNLOAD;
                    idx_d   = ioctl_index;
                end else if (ext_reset) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) state_d = RUN;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rom_addr_d = rom_addr_q;
        rom_data_d = rom_data_q;
        len_base   = rom_start ? '0 : rom_len_q;
        rom_len_d  = len_base;
        dip_d      = dip_q;
        mod_d      = mod_q;
        if (rom_hit) begin
            rom_addr_d = ioctl_addr;
            rom_data_d = ioctl_dout;
            if (addr_p1 > len_base) rom_len_d = addr_p1;
        end
        // Unrolled compare keeps out-of-range DIP addresses harmless.
        for (int k = 0; k < NUM_DIP; k++) begin
            if (dip_hit && (ioctl_addr == AW'(k))) dip_d[8*k +: 8] = ioctl_dout;
        end
        if (ioctl_wr && (ioctl_index == MOD_INDEX)) mod_d = ioctl_dout;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            idx_q        <= '0;
            dl_done_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
            rom_wr_q     <= 1'b0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            rom_len_q    <= '0;
            dip_q        <= '0;
            mod_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            dl_done_q    <= dl_done_d;
            core_rst_n_q <= (state_d == RUN);
            rom_wr_q     <= rom_hit;
            rom_addr_q   <= rom_addr_d;
            rom_data_q   <= rom_data_d;
            rom_len_q    <= rom_len_d;
            dip_q        <= dip_d;
            mod_q        <= mod_d;
        end
    end

`ifdef IOCTL_ROM_CHECKSUM_EN
    logic [15:0] rom_sum_q, rom_sum_d;

    always_comb begin
        rom_sum_d = rom_start ? 16'h0000 : rom_sum_q;
        if (rom_hit) rom_sum_d = rom_sum_d + {8'h00, ioctl_dout};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rom_sum_q <= 16'h0000;
        else          rom_sum_q <= rom_sum_d;
    end

    assign rom_sum = rom_sum_q;
`else
    assign rom_sum = 16'h0000;
`endif

    assign dip          = dip_q;
    assign mod_sel      = mod_q;
    assign rom_wr       = rom_wr_q;
    assign rom_addr     = rom_addr_q;
    assign rom_data     = rom_data_q;
    assign rom_len      = rom_len_q;
    assign dl_done      = dl_done_q;
    assign core_reset_n = core_rst_n_q;

endmodule

// File: tb/tb_arcade_ioctl_router.sv
// Directed bench for arcade_ioctl_router with default parameters.
module tb_arcade_ioctl_router;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ext_reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [63:0] dip;
    logic [7:0]  mod_sel;
    logic        rom_wr;
    logic [24:0] rom_addr;
    logic [7:0]  rom_data;
    logic [25:0] rom_len;
    logic        dl_done;
    logic        core_reset_n;
    logic [15:0] rom_sum;

    int n_chk = 0;
    int n_err = 0;
    int dl_cnt = 0;
    int wr_cnt = 0;
    int n;
    int base_dl, base_wr;
    logic [15:0] exp_sum;

    arcade_ioctl_router dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ext_reset(ext_reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .dip(dip), .mod_sel(mod_sel),
        .rom_wr(rom_wr), .rom_addr(rom_addr), .rom_data(rom_data), .rom_len(rom_len),
        .dl_done(dl_done), .core_reset_n(core_reset_n), .rom_sum(rom_sum)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (dl_done) dl_cnt++;
        if (rom_wr)  wr_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Edges until core_reset_n rises, capped so a stuck reset cannot hang the run.
    task automatic wait_core_up(output int edges);
        edges = 0;
        while (!core_reset_n && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    task automatic ioctl_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        tick();
        ioctl_wr    = 1'b0;
    endtask

    initial begin
`ifdef IOCTL_ROM_CHECKSUM_EN
        exp_sum = 16'h7F80;
`else
        exp_sum = 16'h0000;
`endif
        reset_n = 1'b0; ext_reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_index = 8'd0; ioctl_addr = '0; ioctl_dout = 8'd0;

        // 1: reset state and release timing
        tick(); tick();
        chk("rst_dip", dip, 64'h0);
        chk("rst_mod", {56'h0, mod_sel}, 64'h0);
        chk("rst_rom_wr", {63'h0, rom_wr}, 64'h0);
        chk("rst_rom_len", {38'h0, rom_len}, 64'h0);
        chk("rst_dl_done", {63'h0, dl_done}, 64'h0);
        chk("rst_core", {63'h0, core_reset_n}, 64'h0);
        chk("rst_sum", {48'h0, rom_sum}, 64'h0);
        reset_n = 1'b1;
        wait_core_up(n);
        chk("release_edges", n, 16);

        // 2: DIP download, addresses 8 and 9 must be dropped
        base_dl = dl_cnt; base_wr = wr_cnt;
        ioctl_download = 1'b1; ioctl_index = 8'd254;
        tick();
        chk("dip_core_fall", {63'h0, core_reset_n}, 64'h0);
        for (int a = 0; a < 10; a++) begin
            ioctl_write(8'd254, 25'(a), 8'hA0 + 8'(a));
            if (core_reset_n) chk("dip_core_low", {63'h0, core_reset_n}, 64'h0);
            tick();
        end
        chk("dip_during", dip, 64'hA7A6A5A4A3A2A1A0);
        ioctl_download = 1'b0;
        tick();
        chk("dip_value", dip, 64'hA7A6A5A4A3A2A1A0);
        wait_core_up(n);
        chk("dip_core_edges", n, 16);
        chk("dip_no_dl_done", dl_cnt - base_dl, 0);
        chk("dip_no_rom_wr", wr_cnt - base_wr, 0);

        // 3: ROM download of 256 bytes
        base_dl = dl_cnt; base_wr = wr_cnt;
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        tick();
        for (int a = 0; a < 256; a++) begin
            ioctl_write(8'd0, 25'(a), 8'(a));
            chk("rom_wr_pulse", {63'h0, rom_wr}, 64'h1);
            chk("rom_addr", {39'h0, rom_addr}, 64'(a));
            chk("rom_data", {56'h0, rom_data}, 64'(a & 255));
            tick();
            chk("rom_wr_gap", {63'h0, rom_wr}, 64'h0);
        end
        ioctl_download = 1'b0;
        tick();
        chk("rom_dl_done", {63'h0, dl_done}, 64'h1);
        chk("rom_len", {38'h0, rom_len}, 64'd256);
        chk("rom_sum", {48'h0, rom_sum}, {48'h0, exp_sum});
        wait_core_up(n);
        chk("rom_core_edges", n, 16);
        chk("rom_dl_count", dl_cnt - base_dl, 1);
        chk("rom_wr_count", wr_cnt - base_wr, 256);

        // 4: mod byte, and writes outside a download
        base_wr = wr_cnt;
        ioctl_write(8'd1, 25'd5, 8'h01);
        chk("mod_first", {56'h0, mod_sel}, 64'h01);
        tick();
        ioctl_write(8'd1, 25'd0, 8'h00);
        chk("mod_second", {56'h0, mod_sel}, 64'h00);
        ioctl_write(8'd254, 25'd7, 8'h55);
        chk("dip_no_dl", dip, 64'h55A6A5A4A3A2A1A0);
        ioctl_write(8'd0, 25'd3, 8'hEE);
        tick();
        chk("rom_no_dl", wr_cnt - base_wr, 0);
        chk("core_still_run", {63'h0, core_reset_n}, 64'h1);

        // 5: ext_reset for 3 clocks, then a re-pulse inside HOLD
        ext_reset = 1'b1;
        tick();
        chk("ext_fall", {63'h0, core_reset_n}, 64'h0);
        tick(); tick();
        ext_reset = 1'b0;
        wait_core_up(n);
        chk("ext_edges", n, 16);
        ext_reset = 1'b1; tick(); ext_reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        ext_reset = 1'b1; tick(); ext_reset = 1'b0;
        wait_core_up(n);
        chk("ext_restart_edges", n, 16);

        // 6: reset_n mid ROM download
        base_dl = dl_cnt;
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        tick();
        chk("rom_len_clear", {38'h0, rom_len}, 64'h0);
        for (int a = 0; a < 100; a++) ioctl_write(8'd0, 25'(a), 8'(a));
        chk("abort_len_pre", {38'h0, rom_len}, 64'd100);
        ioctl_addr = 25'd100; ioctl_dout = 8'd100; ioctl_wr = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("abort_rom_len", {38'h0, rom_len}, 64'h0);
        chk("abort_dip", dip, 64'h0);
        chk("abort_core", {63'h0, core_reset_n}, 64'h0);
        chk("abort_rom_addr", {39'h0, rom_addr}, 64'h0);
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        wait_core_up(n);
        chk("abort_edges", n, 16);
        chk("abort_no_dl_done", dl_cnt - base_dl, 0);
        chk("abort_len_after", {38'h0, rom_len}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
